// File: rtl/muldiv_unit.sv
// Multi-cycle mult/div with HI/LO: result lands MUL_CYCLES/DIV_CYCLES edges after the accepting edge.
// No backpressure of its own: Busy is exported, and Start/MoveTo seen while Busy are dropped.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic        MoveTo,
  input  logic        MoveFrom,
  input  logic [2:0]  Sel,
  input  logic        Cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] SEL_MUL  = 3'd0;
  localparam logic [2:0] SEL_MULU = 3'd1;
  localparam logic [2:0] SEL_DIV  = 3'd2;
  localparam logic [2:0] SEL_DIVU = 3'd3;
  localparam logic [2:0] SEL_HI   = 3'd4;
  localparam logic [2:0] SEL_LO   = 3'd5;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, dvd, dvs, quo, rem;
  logic [31:0] res_hi, res_lo;
  logic        acc, start_ok;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide runs on magnitudes through the one shared divider; signs are fixed up after.
  assign a_mag = A[31] ? (32'd0 - A) : A;
  assign b_mag = B[31] ? (32'd0 - B) : B;
  assign dvd   = (Sel == SEL_DIV) ? a_mag : A;
  assign dvs   = (Sel == SEL_DIV) ? b_mag : B;
  assign quo   = dvd / dvs;
  assign rem   = dvd % dvs;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (Sel)
      SEL_MUL:  {res_hi, res_lo} = prod_s;
      SEL_MULU: {res_hi, res_lo} = prod_u;
      SEL_DIV: begin
        if (B != 32'd0) begin
          res_lo = (A[31] ^ B[31]) ? (32'd0 - quo) : quo;
          res_hi = A[31] ? (32'd0 - rem) : rem;
        end
      end
      SEL_DIVU: begin
        if (B != 32'd0) begin
          res_lo = quo;
          res_hi = rem;
        end
      end
      default: ;
    endcase
  end

  assign Busy     = (cnt_q != '0);
  assign acc      = !Cancel && !Busy;
  assign start_ok = Start && acc && !Sel[2];

  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    if (start_ok) begin
      sh_hi_d = res_hi;
      sh_lo_d = res_lo;
      cnt_d   = Sel[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    end else if (MoveTo && acc && !Start) begin
      if (Sel == SEL_HI) hi_d = A;
      if (Sel == SEL_LO) lo_d = A;
    end
    // acc implies cnt_q==0, so commit below never collides with a new start or move.
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d = sh_hi_q;
        lo_d = sh_lo_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  always_comb begin
    Out = 32'd0;
    if (MoveFrom && Sel == SEL_HI) Out = hi_q;
    if (MoveFrom && Sel == SEL_LO) Out = lo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at issue, popped when Busy drops.
module tb_muldiv_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start, MoveTo, MoveFrom, Cancel;
  logic [2:0]  Sel;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] Out;

  int   vec = 0;
  int   miscmp = 0;
  res_t sb[$];

  muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .MoveTo(MoveTo), .MoveFrom(MoveFrom),
    .Sel(Sel), .Cancel(Cancel), .A(A), .B(B), .Busy(Busy), .Out(Out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec);
    $fatal(1, "watchdog");
  end

  // Helpers only drive/observe; every comparison lives in the test tasks.
  task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       output logic busy_at_start);
    Start = 1'b1; Sel = sel; A = a; B = b;
    #1 busy_at_start = Busy;
    @(negedge clk);
    Start = 1'b0; Sel = 3'd7;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    MoveFrom = 1'b1; Sel = 3'd4;
    #1 hi = Out;
    Sel = 3'd5;
    #1 lo = Out;
    MoveFrom = 1'b0; Sel = 3'd7;
  endtask

  task automatic move_to(input logic [2:0] sel, input logic [31:0] a, input logic cancel);
    MoveTo = 1'b1; Sel = sel; A = a; Cancel = cancel;
    @(negedge clk);
    MoveTo = 1'b0; Sel = 3'd7; Cancel = 1'b0;
  endtask

  task automatic model(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       output res_t r);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    int              ia, ib;
    r = '0;
    case (sel)
      3'd0: begin sa = $signed(a); sb = $signed(b); p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'd1: begin ua = {32'd0, a}; ub = {32'd0, b}; p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'd2: begin ia = a; ib = b; r.lo = ia / ib; r.hi = ia % ib; end
      default: begin r.lo = a / b; r.hi = a % b; end
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles);
    logic        bz;
    int          n;
    logic [31:0] hi, lo;
    res_t        e;
    issue(sel, a, b, bz);
    vec++;
    if (bz !== 1'b0) begin
      miscmp++; $display("FAIL %s busy_in_start: got %b want 0", name, bz);
    end
    wait_idle(n);
    vec++;
    if (n != exp_cycles) begin
      miscmp++; $display("FAIL %s busy_cycles: got %0d want %0d", name, n, exp_cycles);
    end
    read_hilo(hi, lo);
    vec++;
    if (sb.size() == 0) begin
      miscmp++; $display("FAIL %s scoreboard: empty, got hi=%h lo=%h", name, hi, lo);
    end else begin
      e = sb.pop_front();
      if (hi !== e.hi || lo !== e.lo) begin
        miscmp++;
        $display("FAIL %s hilo: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] hi, lo;
    read_hilo(hi, lo);
    vec++;
    if (Busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscmp++; $display("FAIL reset: busy=%b hi=%h lo=%h want 0/0/0", Busy, hi, lo);
    end
  endtask

  task automatic test_mult;
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA});
    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5);
  endtask

  task automatic test_multu;
    sb.push_back('{hi: 32'h00000002, lo: 32'hFFFFFFFA});
    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5);
  endtask

  task automatic test_div;
    sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10);
    sb.push_back('{hi: 32'h00000000, lo: 32'h80000000});
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10);
  endtask

  task automatic test_divu_zero;
    move_to(3'd4, 32'd1, 1'b0);
    move_to(3'd5, 32'd2, 1'b0);
    sb.push_back('{hi: 32'd1, lo: 32'd2});
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 10);
  endtask

  task automatic test_move_cancel;
    logic [31:0] hi, lo;
    move_to(3'd4, 32'h1234, 1'b0);
    MoveFrom = 1'b1; Sel = 3'd4;
    #1 vec++;
    if (Out !== 32'h1234) begin
      miscmp++; $display("FAIL mthi: got %h want 00001234", Out);
    end
    MoveFrom = 1'b0; Sel = 3'd7;
    move_to(3'd5, 32'hDEAD, 1'b1);
    read_hilo(hi, lo);
    vec++;
    if (lo !== 32'd2) begin
      miscmp++; $display("FAIL mtlo_cancel: got %h want 00000002", lo);
    end
    Start = 1'b1; Cancel = 1'b1; Sel = 3'd0; A = 32'd9; B = 32'd9;
    @(negedge clk);
    Start = 1'b0; Cancel = 1'b0; Sel = 3'd7;
    vec++;
    if (Busy !== 1'b0) begin
      miscmp++; $display("FAIL start_cancel: busy got %b want 0", Busy);
    end
  endtask

  task automatic test_cancel_during_busy;
    logic        bz;
    int          n;
    logic [31:0] hi, lo;
    sb.push_back('{hi: 32'd2, lo: 32'd14});
    issue(3'd2, 32'd100, 32'd7, bz);
    @(negedge clk);
    Cancel = 1'b1;
    @(negedge clk);
    Cancel = 1'b0;
    Start = 1'b1; Sel = 3'd1; A = 32'd5; B = 32'd5;
    @(negedge clk);
    Start = 1'b0; Sel = 3'd7;
    wait_idle(n);
    vec++;
    if (n != 7) begin
      miscmp++; $display("FAIL busy_start_ignored: remaining cycles got %0d want 7", n);
    end
    read_hilo(hi, lo);
    e_check: begin
      res_t e;
      vec++;
      if (sb.size() == 0) begin
        miscmp++; $display("FAIL cancel_busy scoreboard: empty");
      end else begin
        e = sb.pop_front();
        if (hi !== e.hi || lo !== e.lo) begin
          miscmp++;
          $display("FAIL cancel_busy hilo: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic        bz;
    logic [31:0] hi, lo;
    issue(3'd0, 32'd3, 32'd4, bz);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    read_hilo(hi, lo);
    vec++;
    if (Busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscmp++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0/0/0", Busy, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back('{hi: 32'd1, lo: 32'd0});
    run_op("mult_after_reset", 3'd0, 32'h00010000, 32'h00010000, 5);
  endtask

  task automatic test_random;
    logic [2:0]  sel;
    logic [31:0] a, b;
    res_t        e;
    for (int i = 0; i < 8; i++) begin
      sel = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (b == 32'd0) b = 32'd1;
      if (b == 32'hFFFFFFFF) b = 32'd3;
      model(sel, a, b, e);
      sb.push_back(e);
      run_op("random", sel, a, b, sel[1] ? 10 : 5);
    end
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; MoveTo = 1'b0; MoveFrom = 1'b0; Cancel = 1'b0;
    Sel = 3'd7; A = '0; B = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_mult;
    test_multu;
    test_div;
    test_divu_zero;
    test_move_cancel;
    test_cancel_during_busy;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
